// File: rtl/tfe_pkg.sv
// tfe_pkg -- shared constants and types for the hash reuse judge.
//   TFE_HASH_W : default hash width in bits
//   TFE_DEPTH  : default number of history-table entries
//   tfe_res_t  : result bundle {hit, idx, hash} at the default sizes
package tfe_pkg;

  localparam int TFE_HASH_W = 16;
  localparam int TFE_DEPTH  = 16;
  localparam int TFE_IDX_W  = $clog2(TFE_DEPTH);

  typedef struct packed {
    logic                  hit;
    logic [TFE_IDX_W-1:0]  idx;
    logic [TFE_HASH_W-1:0] hash;
  } tfe_res_t;

endpackage

// File: rtl/tfe_hash_match.sv
// tfe_hash_match -- parallel compare of a key against every valid table entry
// with lowest-index priority encoding. Purely combinational.
//   i_tbl   : table contents, entry k in i_tbl[k]
//   i_valid : per-entry valid bits
//   i_key   : hash to look up
//   o_hit   : at least one valid entry equals the key
//   o_idx   : lowest matching index (0 when no hit)
module tfe_hash_match
  import tfe_pkg::*;
#(
  parameter int HASH_W = TFE_HASH_W,
  parameter int DEPTH  = TFE_DEPTH,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0][HASH_W-1:0] i_tbl,
  input  logic [DEPTH-1:0]             i_valid,
  input  logic [HASH_W-1:0]            i_key,
  output logic                         o_hit,
  output logic [IDX_W-1:0]             o_idx
);

  // Scan from the top down so the lowest matching index is the last one written.
  always_comb begin
    o_hit = 1'b0;
    o_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (i_valid[i] && (i_tbl[i] == i_key)) begin
        o_hit = 1'b1;
        o_idx = IDX_W'(i);
      end else begin
        o_hit = o_hit;
        o_idx = o_idx;
      end
    end
  end

endmodule

// File: rtl/tfe_hash_reuse_judge.sv
// tfe_hash_reuse_judge -- judges whether an incoming hash was seen recently.
// A DEPTH-entry history table is searched in one cycle; misses are inserted
// FIFO-style at wr_ptr (oldest entry evicted). The result appears one cycle
// after acceptance and is held under downstream backpressure.
//   clk, rst_n            : clock, asynchronous active-low reset
//   i_hash/i_hash_valid   : incoming hash, o_hash_ready accepts it
//   i_flush               : one-cycle pulse that empties the table
//   o_res_valid/i_res_ready: result handshake; o_res_hit/o_res_idx/o_res_hash
//   o_fill                : number of valid table entries (0..DEPTH)
// Optional: define TFE_HASH_JUDGE_STATS_EN to add saturating o_hit_cnt and
// o_miss_cnt counters (cleared by reset and by i_flush).
module tfe_hash_reuse_judge
  import tfe_pkg::*;
#(
  parameter int HASH_W = TFE_HASH_W,
  parameter int DEPTH  = TFE_DEPTH,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [HASH_W-1:0] i_hash,
  input  logic              i_hash_valid,
  output logic              o_hash_ready,
  input  logic              i_flush,
  output logic              o_res_valid,
  input  logic              i_res_ready,
  output logic              o_res_hit,
  output logic [IDX_W-1:0]  o_res_idx,
  output logic [HASH_W-1:0] o_res_hash,
  output logic [IDX_W:0]    o_fill
`ifdef TFE_HASH_JUDGE_STATS_EN
  ,
  output logic [31:0]       o_hit_cnt,
  output logic [31:0]       o_miss_cnt
`endif
);

  typedef struct packed {
    logic              hit;
    logic [IDX_W-1:0]  idx;
    logic [HASH_W-1:0] hash;
  } res_t;

  localparam logic [IDX_W:0] FILL_MAX = (IDX_W + 1)'(DEPTH);

  logic [DEPTH-1:0][HASH_W-1:0] tbl_q, tbl_d;
  logic [DEPTH-1:0]             vld_q, vld_d;
  logic [IDX_W-1:0]             wr_ptr_q, wr_ptr_d;
  logic [IDX_W:0]               fill_q, fill_d;
  logic                         res_valid_q, res_valid_d;
  res_t                         res_q, res_d;
  logic                         hash_ready_s;
  logic                         accept_s;
  logic                         match_hit_s;
  logic [IDX_W-1:0]             match_idx_s;

  tfe_hash_match #(
    .HASH_W (HASH_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_match (
    .i_tbl   (tbl_q),
    .i_valid (vld_q),
    .i_key   (i_hash),
    .o_hit   (match_hit_s),
    .o_idx   (match_idx_s)
  );

  // Ready: flush blocks acceptance; otherwise accept when the result slot frees.
  always_comb begin
    hash_ready_s = !i_flush && (!res_valid_q || i_res_ready);
    accept_s     = i_hash_valid && hash_ready_s;
  end

  // Next-state for the result register and the history table.
  always_comb begin
    res_valid_d = res_valid_q;
    res_d       = res_q;
    tbl_d       = tbl_q;
    vld_d       = vld_q;
    wr_ptr_d    = wr_ptr_q;
    fill_d      = fill_q;

    // Flush never touches the pending result, only a handshake does.
    if (accept_s) begin
      res_valid_d = 1'b1;
      res_d.hit   = match_hit_s;
      res_d.idx   = match_hit_s ? match_idx_s : wr_ptr_q;
      res_d.hash  = i_hash;
    end else if (res_valid_q && i_res_ready) begin
      res_valid_d = 1'b0;
    end else begin
      res_valid_d = res_valid_q;
    end

    // accept_s already excludes the flush cycle, so the branches are disjoint.
    if (i_flush) begin
      vld_d    = '0;
      wr_ptr_d = '0;
      fill_d   = '0;
    end else if (accept_s && !match_hit_s) begin
      tbl_d[wr_ptr_q] = i_hash;
      vld_d[wr_ptr_q] = 1'b1;
      wr_ptr_d        = wr_ptr_q + IDX_W'(1'b1); // power-of-two depth wraps naturally
      fill_d          = (fill_q < FILL_MAX) ? (fill_q + (IDX_W + 1)'(1'b1)) : fill_q;
    end else begin
      fill_d = fill_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl_q       <= '0;
      vld_q       <= '0;
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      res_valid_q <= 1'b0;
      res_q       <= '0;
    end else begin
      tbl_q       <= tbl_d;
      vld_q       <= vld_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_q      <= fill_d;
      res_valid_q <= res_valid_d;
      res_q       <= res_d;
    end
  end

  assign o_hash_ready = hash_ready_s;
  assign o_res_valid  = res_valid_q;
  assign o_res_hit    = res_q.hit;
  assign o_res_idx    = res_q.idx;
  assign o_res_hash   = res_q.hash;
  assign o_fill       = fill_q;

`ifdef TFE_HASH_JUDGE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  // Saturating hit/miss counters, emptied together with the table.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (i_flush) begin
      hit_cnt_d  = 32'd0;
      miss_cnt_d = 32'd0;
    end else if (accept_s && match_hit_s) begin
      hit_cnt_d = (hit_cnt_q != 32'hFFFF_FFFF) ? (hit_cnt_q + 32'd1) : hit_cnt_q;
    end else if (accept_s) begin
      miss_cnt_d = (miss_cnt_q != 32'hFFFF_FFFF) ? (miss_cnt_q + 32'd1) : miss_cnt_q;
    end else begin
      hit_cnt_d  = hit_cnt_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= 32'd0;
      miss_cnt_q <= 32'd0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign o_hit_cnt  = hit_cnt_q;
  assign o_miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_tfe_hash_reuse_judge.sv
// tb_tfe_hash_reuse_judge -- directed scenarios plus randomized traffic for
// tfe_hash_reuse_judge (default HASH_W=16, DEPTH=16), checked against a
// queue-based history model. Inputs change on the falling edge, outputs are
// sampled 1 time unit after the rising edge.
module tb_tfe_hash_reuse_judge;

  localparam int HASH_W = 16;
  localparam int DEPTH  = 16;
  localparam int IDX_W  = 4;

  logic              clk;
  logic              rst_n;
  logic [HASH_W-1:0] i_hash;
  logic              i_hash_valid;
  logic              o_hash_ready;
  logic              i_flush;
  logic              o_res_valid;
  logic              i_res_ready;
  logic              o_res_hit;
  logic [IDX_W-1:0]  o_res_idx;
  logic [HASH_W-1:0] o_res_hash;
  logic [IDX_W:0]    o_fill;
`ifdef TFE_HASH_JUDGE_STATS_EN
  logic [31:0]       o_hit_cnt;
  logic [31:0]       o_miss_cnt;
`endif

  tfe_hash_reuse_judge #(.HASH_W(HASH_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_hash       (i_hash),
    .i_hash_valid (i_hash_valid),
    .o_hash_ready (o_hash_ready),
    .i_flush      (i_flush),
    .o_res_valid  (o_res_valid),
    .i_res_ready  (i_res_ready),
    .o_res_hit    (o_res_hit),
    .o_res_idx    (o_res_idx),
    .o_res_hash   (o_res_hash),
    .o_fill       (o_fill)
`ifdef TFE_HASH_JUDGE_STATS_EN
    ,
    .o_hit_cnt    (o_hit_cnt),
    .o_miss_cnt   (o_miss_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: the history is the list of recent misses, oldest first,
  // each remembered with the slot it landed in (miss ordinal modulo DEPTH).
  typedef struct { int hash; int slot; } ent_t;
  ent_t hist[$];
  int   miss_total;
  bit   exp_valid;
  bit   exp_hit;
  int   exp_idx;
  int   exp_hash;
  longint exp_hits;
  longint exp_misses;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic model_clear();
    hist.delete();
    miss_total = 0;
    exp_hits   = 0;
    exp_misses = 0;
  endtask

  task automatic model_judge(input int h);
    int best;
    best = -1;
    foreach (hist[k]) begin
      if (hist[k].hash == h && (best < 0 || hist[k].slot < best)) best = hist[k].slot;
    end
    exp_valid = 1'b1;
    exp_hash  = h;
    if (best >= 0) begin
      exp_hit = 1'b1;
      exp_idx = best;
      exp_hits++;
    end else begin
      ent_t e;
      e.hash = h;
      e.slot = miss_total % DEPTH;
      exp_hit = 1'b0;
      exp_idx = e.slot;
      hist.push_back(e);
      if (hist.size() > DEPTH) void'(hist.pop_front());
      miss_total++;
      exp_misses++;
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".valid"}, 64'(o_res_valid), 64'(exp_valid));
    if (exp_valid) begin
      chk({tag, ".hit"},  64'(o_res_hit),  64'(exp_hit));
      chk({tag, ".idx"},  64'(o_res_idx),  64'(exp_idx));
      chk({tag, ".hash"}, 64'(o_res_hash), 64'(exp_hash));
    end
    chk({tag, ".fill"}, 64'(o_fill), 64'(hist.size()));
`ifdef TFE_HASH_JUDGE_STATS_EN
    chk({tag, ".hits"},   64'(o_hit_cnt),  64'(exp_hits));
    chk({tag, ".misses"}, 64'(o_miss_cnt), 64'(exp_misses));
`endif
  endtask

  // One clock cycle: drive at the falling edge, check ready, then check the
  // registered outputs just after the rising edge against the model.
  task automatic step(input string tag, input bit v, input int h, input bit rdy, input bit fl);
    bit exp_rdy;
    bit acc;
    i_hash_valid = v;
    i_hash       = h[HASH_W-1:0];
    i_res_ready  = rdy;
    i_flush      = fl;
    #1;
    exp_rdy = !fl && (!exp_valid || rdy);
    chk({tag, ".ready"}, 64'(o_hash_ready), 64'(exp_rdy));
    acc = v && exp_rdy;
    @(posedge clk);
    if (acc) model_judge(h);
    else if (exp_valid && rdy) exp_valid = 1'b0;
    if (fl) model_clear();
    #1;
    check_outputs(tag);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    exp_valid = 1'b0;
    model_clear();
    chk("rst.valid", 64'(o_res_valid), 64'd0);
    chk("rst.hit",   64'(o_res_hit),   64'd0);
    chk("rst.idx",   64'(o_res_idx),   64'd0);
    chk("rst.hash",  64'(o_res_hash),  64'd0);
    chk("rst.fill",  64'(o_fill),      64'd0);
    chk("rst.ready", 64'(o_hash_ready), 64'(!i_flush));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n        = 1'b0;
    i_hash       = '0;
    i_hash_valid = 1'b0;
    i_flush      = 1'b0;
    i_res_ready  = 1'b1;
    exp_valid    = 1'b0;
    model_clear();
    @(negedge clk);
    apply_reset();

    // Ten new hashes, then the same ten again.
    for (int i = 0; i < 20; i++) step("seq10", 1'b1, i % 10, 1'b1, 1'b0);
    step("seq10.drain", 1'b0, 0, 1'b1, 1'b0);
    chk("seq10.fill", 64'(o_fill), 64'd10);

    // Overflow the table so the oldest entries are evicted FIFO-style.
    step("flush1", 1'b0, 0, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) step("wrap", 1'b1, i, 1'b1, 1'b0);
    step("wrap.h0", 1'b1, 0, 1'b1, 1'b0);
    chk("wrap.h0.idx", 64'(o_res_idx), 64'd4);
    chk("wrap.fill16", 64'(o_fill), 64'd16);

    // Same hash on consecutive cycles: miss, then hit.
    step("flush2", 1'b0, 0, 1'b1, 1'b1);
    step("b2b.a", 1'b1, 5, 1'b1, 1'b0);
    step("b2b.b", 1'b1, 5, 1'b1, 1'b0);
    chk("b2b.hit", 64'(o_res_hit), 64'd1);

    // Backpressure: five stalled cycles, then drain one result per cycle.
    step("stall.first", 1'b1, 100, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step("stall", 1'b1, 101, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step("release", 1'b1, 101 + i, 1'b1, 1'b0);

    // Flush after loading 0..3; a hash offered in the flush cycle is ignored.
    step("flush3", 1'b0, 0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step("load", 1'b1, i, 1'b1, 1'b0);
    step("flush.cycle", 1'b1, 2, 1'b1, 1'b1);
    step("post.flush", 1'b1, 2, 1'b1, 1'b0);
    chk("post.flush.idx", 64'(o_res_idx), 64'd0);

    // Reset while a result is stalled.
    step("prerst", 1'b1, 9, 1'b1, 1'b0);
    step("prerst.stall", 1'b1, 10, 1'b0, 1'b0);
    apply_reset();
    step("postrst.idle", 1'b0, 0, 1'b1, 1'b0);
    step("postrst.h7", 1'b1, 7, 1'b1, 1'b0);

    // Randomized traffic over a small hash range so hits and eviction both occur.
    for (int i = 0; i < 600; i++) begin
      step("rand", ($urandom_range(0, 3) != 0), $urandom_range(0, 23),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 49) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
